// File: rtl/rx_data_receive.sv
// Receive-side data path: delivers N-Chars to the RX FIFO and time-codes to the host,
// tracks the receive credit granted to the remote end and flags credit/overflow errors.
module rx_data_receive #(
   parameter int unsigned MAX_CREDIT = 56,
   parameter int unsigned FCT_CHUNK  = 8,
   parameter int unsigned FIFO_AW    = 6
) (
   input  logic               pclk_rx,
   input  logic               reset_rx,
   input  logic               enable_rx,
   input  logic               rx_got_nchar,
   input  logic [8:0]         rx_nchar_i,
   input  logic               rx_got_time_code,
   input  logic [7:0]         rx_time_code_i,
   input  logic               rx_got_fct,
   input  logic               fct_sent,
   input  logic [FIFO_AW:0]   fifo_free,
   output logic [8:0]         rx_data_o,
   output logic               rx_data_wr,
   output logic [7:0]         time_out,
   output logic               tick_out,
   output logic               fct_request,
   output logic               tx_credit_inc,
   output logic [5:0]         rx_credit,
   output logic               credit_error,
   output logic               overflow_error
);

   typedef enum logic [1:0] {StIdle, StRun, StError} state_e;

   // Credit arithmetic is done at a comfortable width so sums never wrap.
   localparam logic [15:0] MaxCredit = 16'(MAX_CREDIT);
   localparam logic [15:0] FctChunk  = 16'(FCT_CHUNK);

   state_e      state_q, state_d;
   logic [8:0]  data_q, data_d;
   logic        wr_q, wr_d;
   logic [7:0]  time_q, time_d;
   logic        tick_q, tick_d;
   logic        req_q, req_d;
   logic        inc_q, inc_d;
   logic [5:0]  credit_q, credit_d;
   logic        cerr_q, cerr_d;
   logic        oerr_q, oerr_d;

   logic [15:0] credit_ext;
   logic [15:0] free_ext;
   logic [15:0] credit_sum;
   logic [15:0] accept_ext;
   logic [5:0]  time_seq;
   logic        accept;
   logic        err_now;

   assign credit_ext = 16'(credit_q);
   assign free_ext   = 16'(fifo_free);
   assign time_seq   = time_q[5:0] + 6'd1;

   // Next-state: FSM, N-Char acceptance, credit, time-code and FCT handling.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      wr_d       = 1'b0;
      time_d     = time_q;
      tick_d     = 1'b0;
      req_d      = 1'b0;
      inc_d      = 1'b0;
      credit_d   = credit_q;
      cerr_d     = cerr_q;
      oerr_d     = oerr_q;
      accept     = 1'b0;
      err_now    = 1'b0;
      accept_ext = 16'd0;
      credit_sum = credit_ext;

      if (!enable_rx) begin
         state_d  = StIdle;
         data_d   = '0;
         time_d   = '0;
         credit_d = '0;
         cerr_d   = 1'b0;
         oerr_d   = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: state_d = StRun;
            StRun: begin
               if (rx_got_nchar) begin
                  if (credit_q == 6'd0) begin
                     cerr_d  = 1'b1;
                     err_now = 1'b1;
                  end else if (fifo_free == '0) begin
                     oerr_d  = 1'b1;
                     err_now = 1'b1;
                  end else begin
                     accept = 1'b1;
                     data_d = rx_nchar_i;
                     wr_d   = 1'b1;
                  end
               end
               // Time-codes and FCTs are still honoured in the cycle an N-Char errors.
               if (rx_got_time_code) begin
                  time_d = rx_time_code_i;
                  tick_d = (rx_time_code_i[5:0] == time_seq);
               end
               inc_d = rx_got_fct;

               accept_ext = 16'(accept);
               credit_sum = credit_ext - accept_ext + (fct_sent ? FctChunk : 16'd0);
               if (credit_sum > MaxCredit) begin
                  // Remote TX sent an FCT we could not have granted.
                  credit_d = MaxCredit[5:0];
                  cerr_d   = 1'b1;
                  err_now  = 1'b1;
               end else begin
                  credit_d = credit_sum[5:0];
               end

               // A pending request is held until the TX side reports the FCT sent.
               if (err_now || fct_sent) begin
                  req_d = 1'b0;
               end else if (req_q) begin
                  req_d = 1'b1;
               end else begin
                  req_d = (credit_ext + FctChunk <= MaxCredit) &&
                          (credit_ext + FctChunk <= free_ext);
               end

               if (err_now) state_d = StError;
            end
            StError: state_d = StError;
            default: state_d = StIdle;
         endcase
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge pclk_rx or posedge reset_rx) begin
      if (reset_rx) begin
         state_q  <= StIdle;
         data_q   <= '0;
         wr_q     <= 1'b0;
         time_q   <= '0;
         tick_q   <= 1'b0;
         req_q    <= 1'b0;
         inc_q    <= 1'b0;
         credit_q <= '0;
         cerr_q   <= 1'b0;
         oerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         wr_q     <= wr_d;
         time_q   <= time_d;
         tick_q   <= tick_d;
         req_q    <= req_d;
         inc_q    <= inc_d;
         credit_q <= credit_d;
         cerr_q   <= cerr_d;
         oerr_q   <= oerr_d;
      end
   end

   assign rx_data_o      = data_q;
   assign rx_data_wr     = wr_q;
   assign time_out       = time_q;
   assign tick_out       = tick_q;
   assign fct_request    = req_q;
   assign tx_credit_inc  = inc_q;
   assign rx_credit      = credit_q;
   assign credit_error   = cerr_q;
   assign overflow_error = oerr_q;

endmodule

// File: tb/tb_rx_data_receive.sv
// Bench for rx_data_receive: directed scenarios plus random traffic, checked against a
// behavioural model; pulse outputs are checked by a scoreboard monitor.
module tb_rx_data_receive;

   logic       pclk_rx = 1'b0;
   logic       reset_rx = 1'b1;
   logic       enable_rx = 1'b0;
   logic       rx_got_nchar = 1'b0;
   logic [8:0] rx_nchar_i = '0;
   logic       rx_got_time_code = 1'b0;
   logic [7:0] rx_time_code_i = '0;
   logic       rx_got_fct = 1'b0;
   logic       fct_sent = 1'b0;
   logic [6:0] fifo_free = '0;
   logic [8:0] rx_data_o;
   logic       rx_data_wr;
   logic [7:0] time_out;
   logic       tick_out;
   logic       fct_request;
   logic       tx_credit_inc;
   logic [5:0] rx_credit;
   logic       credit_error;
   logic       overflow_error;

   rx_data_receive dut (
      .pclk_rx          (pclk_rx),
      .reset_rx         (reset_rx),
      .enable_rx        (enable_rx),
      .rx_got_nchar     (rx_got_nchar),
      .rx_nchar_i       (rx_nchar_i),
      .rx_got_time_code (rx_got_time_code),
      .rx_time_code_i   (rx_time_code_i),
      .rx_got_fct       (rx_got_fct),
      .fct_sent         (fct_sent),
      .fifo_free        (fifo_free),
      .rx_data_o        (rx_data_o),
      .rx_data_wr       (rx_data_wr),
      .time_out         (time_out),
      .tick_out         (tick_out),
      .fct_request      (fct_request),
      .tx_credit_inc    (tx_credit_inc),
      .rx_credit        (rx_credit),
      .credit_error     (credit_error),
      .overflow_error   (overflow_error)
   );

   always #5 pclk_rx = ~pclk_rx;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: mode 0 = idle, 1 = running, 2 = stopped on error.
   int         m_mode = 0;
   int         m_credit = 0;
   bit         m_cerr = 0;
   bit         m_oerr = 0;
   bit         m_req = 0;
   logic [7:0] m_time = '0;
   logic [8:0] q_data[$];
   logic [7:0] q_tick[$];
   int         exp_inc = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_status();
      chk("rx_credit", int'(rx_credit), m_credit);
      chk("credit_error", int'(credit_error), int'(m_cerr));
      chk("overflow_error", int'(overflow_error), int'(m_oerr));
      chk("fct_request", int'(fct_request), int'(m_req));
      chk("time_out", int'(time_out), int'(m_time));
   endtask

   task automatic model_clear();
      m_mode = 0; m_credit = 0; m_cerr = 0; m_oerr = 0; m_req = 0; m_time = '0;
   endtask

   // One clock of the model, from the inputs currently driven.
   task automatic model_step();
      int  acc;
      int  nc;
      bit  err;
      bit  req_new;
      logic [5:0] seq;
      if (!enable_rx) begin
         model_clear();
         return;
      end
      if (m_mode == 0) begin
         m_mode = 1;
         m_req = 0;
         return;
      end
      if (m_mode == 2) begin
         m_req = 0;
         return;
      end
      acc = 0;
      err = 0;
      if (rx_got_nchar) begin
         if (m_credit == 0) begin
            m_cerr = 1; err = 1;
         end else if (fifo_free == 0) begin
            m_oerr = 1; err = 1;
         end else begin
            acc = 1;
            q_data.push_back(rx_nchar_i);
         end
      end
      if (rx_got_time_code) begin
         seq = m_time[5:0] + 6'd1;
         if (rx_time_code_i[5:0] == seq) q_tick.push_back(rx_time_code_i);
         m_time = rx_time_code_i;
      end
      if (rx_got_fct) exp_inc++;
      nc = m_credit - acc + (fct_sent ? 8 : 0);
      if (nc > 56) begin
         nc = 56; m_cerr = 1; err = 1;
      end
      if (err || fct_sent) req_new = 0;
      else if (m_req) req_new = 1;
      else req_new = (m_credit + 8 <= 56) && (m_credit + 8 <= int'(fifo_free));
      m_req = req_new;
      m_credit = nc;
      if (err) m_mode = 2;
   endtask

   task automatic apply(input bit en, input bit gn, input logic [8:0] nc, input bit gt,
                        input logic [7:0] tc, input bit gf, input bit fs, input int ff);
      @(negedge pclk_rx);
      check_status();
      enable_rx = en; rx_got_nchar = gn; rx_nchar_i = nc; rx_got_time_code = gt;
      rx_time_code_i = tc; rx_got_fct = gf; fct_sent = fs; fifo_free = 7'(ff);
      model_step();
   endtask

   task automatic idle(input int ff);
      apply(1, 0, '0, 0, '0, 0, 0, ff);
   endtask

   task automatic do_reset();
      @(negedge pclk_rx);
      check_status();
      #2;
      reset_rx = 1'b1;
      enable_rx = 0; rx_got_nchar = 0; rx_got_time_code = 0; rx_got_fct = 0; fct_sent = 0;
      model_clear();
      q_data.delete();
      q_tick.delete();
      exp_inc = 0;
      #1;
      check_status();
      @(negedge pclk_rx);
      reset_rx = 1'b0;
   endtask

   // Scoreboard monitor for the one-cycle output strobes.
   always @(negedge pclk_rx) begin
      if (!reset_rx) begin
         if (rx_data_wr) begin
            if (q_data.size() == 0) chk("unexpected_write", 1, 0);
            else chk("rx_data_o", int'(rx_data_o), int'(q_data.pop_front()));
         end
         if (tick_out) begin
            if (q_tick.size() == 0) chk("unexpected_tick", 1, 0);
            else chk("tick_time", int'(time_out), int'(q_tick.pop_front()));
         end
         if (tx_credit_inc) begin
            chk("tx_credit_inc_expected", int'(exp_inc > 0), 1);
            if (exp_inc > 0) exp_inc--;
         end
      end
   end

   initial begin
      logic [7:0] tcs [5];
      logic [7:0] tc;
      int guard;
      tcs[0] = 8'h3D; tcs[1] = 8'h3E; tcs[2] = 8'h3F; tcs[3] = 8'h00; tcs[4] = 8'h05;

      repeat (2) @(negedge pclk_rx);
      reset_rx = 1'b0;

      // Enable, wait for the request, grant one FCT, then consume all credit.
      idle(64);
      guard = 0;
      while (!m_req && guard < 10) begin idle(64); guard++; end
      chk("fct_request_after_enable", int'(m_req), 1);
      apply(1, 0, '0, 0, '0, 0, 1, 64);
      for (int i = 0; i < 8; i++) apply(1, 1, 9'h041 + 9'(i), 0, '0, 0, 0, 64);
      apply(1, 1, 9'h100, 0, '0, 0, 0, 64);
      repeat (3) apply(1, 1, 9'h0AA, 1, 8'h01, 1, 0, 64);

      // Re-enable, fill credit to the maximum, then a time-code run across the wrap.
      apply(0, 0, '0, 0, '0, 0, 0, 64);
      idle(64);
      guard = 0;
      while (m_credit < 56 && guard < 60) begin
         apply(1, 0, '0, 0, '0, 0, m_req, 64);
         guard++;
      end
      for (int i = 0; i < 5; i++) apply(1, 0, '0, 1, tcs[i], 0, 0, 64);

      // Drain credit to 10, then overflow with fifo_free = 0.
      while (m_credit > 10) apply(1, 1, 9'(m_credit), 0, '0, 0, 0, 64);
      apply(1, 1, 9'h055, 0, '0, 0, 0, 0);
      idle(64);
      apply(0, 0, '0, 0, '0, 0, 0, 64);
      idle(64);

      // Credit 24 then down to 20; combined N-Char + fct_sent + FCT gives 27.
      repeat (3) apply(1, 0, '0, 0, '0, 0, 1, 64);
      repeat (4) apply(1, 1, 9'h033, 0, '0, 0, 0, 64);
      apply(1, 1, 9'h077, 0, '0, 1, 1, 64);
      // 27 -> 20 -> 52, then one more FCT overshoots and saturates.
      repeat (7) apply(1, 1, 9'h011, 0, '0, 0, 0, 64);
      repeat (4) apply(1, 0, '0, 0, '0, 0, 1, 64);
      apply(1, 0, '0, 0, '0, 0, 1, 64);
      idle(64);

      // Mid-run reset drops a pending write.
      apply(0, 0, '0, 0, '0, 0, 0, 64);
      idle(64);
      apply(1, 0, '0, 0, '0, 0, 1, 64);
      apply(1, 1, 9'h0F0, 0, '0, 0, 0, 64);
      do_reset();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom % 400 == 0) begin
            do_reset();
         end else begin
            tc = $urandom;
            if ($urandom % 2 == 0) tc[5:0] = m_time[5:0] + 6'd1;
            apply(($urandom % 64) != 0, ($urandom % 3) == 0, 9'($urandom), ($urandom % 4) == 0,
                  tc, ($urandom % 5) == 0,
                  m_req ? (($urandom % 2) == 0) : (($urandom % 60) == 0),
                  ($urandom % 8 == 0) ? 0 : int'($urandom_range(64, 1)));
         end
      end
      idle(64);
      @(negedge pclk_rx);
      check_status();
      #1;
      chk("pending_writes", q_data.size(), 0);
      chk("pending_ticks", q_tick.size(), 0);
      chk("pending_credit_inc", exp_inc, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rx_data_receive.md
Name: rx_data_receive

Overview:
- Receive-side counterpart of the link's data/time-code transmit path.
- Takes decoded N-Chars, time-codes and FCTs from the RX character decoder and delivers N-Chars to the RX FIFO and time-codes to the host.
- Tracks receive credit granted to the remote end and requests FCTs from the TX side.
- Detects credit and FIFO-overflow errors and reports them to the link state machine.

Parameters:
- MAX_CREDIT, 56, maximum outstanding receive credit (N-Chars).
- FCT_CHUNK, 8, credit granted per FCT sent.
- FIFO_AW, 6, RX FIFO address width; fifo_free is FIFO_AW+1 bits.

Ports:
- pclk_rx  input  1  clock, rising edge.
- reset_rx  input  1  asynchronous, active-high reset.
- enable_rx  input  1  synchronous enable; low clears all state as reset does.
- rx_got_nchar  input  1  decoder strobe: N-Char valid this cycle.
- rx_nchar_i  input  9  N-Char; bit 8 = control flag (EOP/EEP).
- rx_got_time_code  input  1  decoder strobe: time-code valid.
- rx_time_code_i  input  8  time-code; [7:6] flags, [5:0] time.
- rx_got_fct  input  1  decoder strobe: FCT received.
- fct_sent  input  1  TX side sent one FCT this cycle.
- fifo_free  input  FIFO_AW+1  free entries in RX FIFO.
- rx_data_o  output  9  N-Char to RX FIFO.
- rx_data_wr  output  1  RX FIFO write strobe.
- time_out  output  8  last received time-code.
- tick_out  output  1  one-cycle tick on valid sequential time-code.
- fct_request  output  1  request TX side to send an FCT.
- tx_credit_inc  output  1  one-cycle pulse per received FCT (TX credit +8).
- rx_credit  output  6  current outstanding receive credit.
- credit_error  output  1  level; set on N-Char with zero credit.
- overflow_error  output  1  level; set on N-Char with fifo_free==0.

Behaviour:
- Reset (reset_rx high, async) or enable_rx low at clock edge:
  - All outputs 0; rx_data_o=0; time_out=0; rx_credit=0; FSM=IDLE.
- FSM states:
  - IDLE: enable_rx high -> RUN next cycle. No strobes are processed in IDLE.
  - RUN: normal operation. Credit or overflow error -> ERROR.
  - ERROR: all decoder strobes ignored; rx_data_wr, tick_out, tx_credit_inc and fct_request held 0; error flags held. Leaves only via enable_rx low or reset_rx (-> IDLE).
- All outputs are registered; latency is 1 cycle from strobe to output.
- N-Char handling in RUN, on rx_got_nchar:
  - If rx_credit==0: credit_error<=1, no write, FSM->ERROR.
  - Else if fifo_free==0: overflow_error<=1, no write, FSM->ERROR.
  - Else rx_data_o<=rx_nchar_i, rx_data_wr<=1 for one cycle, credit decremented.
- Credit arithmetic, per cycle: rx_credit_next = rx_credit - (accepted nchar) + (fct_sent ? FCT_CHUNK : 0).
  - Simultaneous accepted N-Char and fct_sent gives a net +7.
  - fct_sent that would take rx_credit above MAX_CREDIT: saturate at MAX_CREDIT and set credit_error (TX-side protocol violation); FSM->ERROR.
- fct_request is registered and asserted in RUN when both hold:
  - rx_credit + FCT_CHUNK <= MAX_CREDIT
  - rx_credit + FCT_CHUNK <= fifo_free
  - Deasserted the cycle after fct_sent; re-evaluated each cycle. A request is held until fct_sent.
- Time-code handling in RUN, on rx_got_time_code:
  - time_out<=rx_time_code_i always.
  - tick_out=1 for one cycle only if rx_time_code_i[5:0] == (time_out[5:0]+1) mod 64. Wrap 63->0 ticks.
  - Non-sequential value updates time_out with no tick.
  - First time-code after reset ticks only if its value is 1.
- rx_got_fct in RUN -> tx_credit_inc=1 for one cycle. No internal TX credit counting.
- The three strobes are independent and may coincide; each is processed in the same cycle.
- In the error cycle, a time-code or FCT arriving together with the erroring N-Char is still processed.
- reset_rx mid-operation: immediate clear. Any pending fct_request or write strobe is dropped.

Test Plan:
- Reset, enable, fifo_free=64, no fct_sent -> RUN; fct_request=1; pulse fct_sent -> rx_credit=8, fct_request stays 1 until rx_credit=56 (7 FCTs).
- rx_credit=8, send 8 N-Chars 0x041..0x048, then 0x100 (EOP) -> 8 writes, rx_data_o matches 1 cycle later, rx_credit=0; 9th N-Char -> credit_error=1, no write, strobes then ignored.
- Time-codes 0x3E, 0x3F, 0x00, 0x05 after time_out=0x3D -> tick_out pulses for 0x3E, 0x3F, 0x00; no tick for 0x05; time_out=0x05.
- rx_credit=10, fifo_free=0, N-Char -> overflow_error=1, ERROR; enable_rx low one cycle -> all outputs 0, IDLE.
- Same-cycle accepted N-Char + fct_sent + rx_got_fct at rx_credit=20 -> rx_credit=27, rx_data_wr=1, tx_credit_inc=1.
- rx_credit=52, fct_sent -> rx_credit=56 saturated, credit_error=1.
